// File: rtl/bp_cce_pkg.sv
// rtl/bp_cce_pkg.sv - CCE directory entry types, configurations and sizing helpers
package bp_cce_pkg;

  typedef enum logic [2:0] {
    e_COH_I = 3'd0,
    e_COH_S = 3'd1,
    e_COH_E = 3'd2,
    e_COH_F = 3'd3,
    e_COH_M = 3'd4,
    e_COH_O = 3'd5
  } bp_coh_states_e;

  typedef enum logic [1:0] {
    e_bp_inv_cfg  = 2'd0,
    e_bp_tiny_cfg = 2'd1
  } bp_params_e;

  localparam int dir_tag_width_gp = 20;

  // State sits in the LSBs so a packed row of these matches the RAM layout
  typedef struct packed {
    logic [dir_tag_width_gp-1:0] tag;
    bp_coh_states_e              state;
  } bp_cce_dir_entry_s;

  localparam logic [1:0] e_ready = 2'd0;
  localparam logic [1:0] e_read  = 2'd1;
  localparam logic [1:0] e_done  = 2'd2;

  function automatic int cfg_num_lce(bp_params_e p);
    return (p == e_bp_tiny_cfg) ? 2 : 4;
  endfunction

  function automatic int cfg_lce_assoc(bp_params_e p);
    return (p == e_bp_tiny_cfg) ? 2 : 8;
  endfunction

  function automatic int safe_clog2(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int dir_rows(int num_lce, int assoc, int per_row);
    return (num_lce * assoc) / per_row;
  endfunction

endpackage

// File: rtl/bp_cce_dir_row_cmp.sv
// rtl/bp_cce_dir_row_cmp.sv - combinational tag compare of one directory row with LCE/way decode
module bp_cce_dir_row_cmp
  import bp_cce_pkg::*;
  #(parameter int tag_width_p       = 20
   ,parameter int entries_per_row_p = 8
   ,parameter int lce_assoc_p       = 8
   ,parameter int lce_id_width_p    = 2
   ,parameter int lce_assoc_width_p = 3
   ,parameter int idx_width_p       = 5
   ,localparam int coh_width_lp     = $bits(bp_coh_states_e)
   ,localparam int entry_width_lp   = tag_width_p + coh_width_lp
  )
  (input  logic [entries_per_row_p*entry_width_lp-1:0]          row_i
  ,input  logic [tag_width_p-1:0]                               tag_i
  ,input  logic [idx_width_p-1:0]                               base_i
  ,output logic [entries_per_row_p-1:0]                         hit_o
  ,output logic [entries_per_row_p-1:0][lce_id_width_p-1:0]     lce_o
  ,output logic [entries_per_row_p-1:0][lce_assoc_width_p-1:0]  way_o
  );

  logic [entry_width_lp-1:0] entry;
  int idx;

  always_comb begin
    hit_o = '0;
    lce_o = '0;
    way_o = '0;
    entry = '0;
    idx   = 0;
    for (int j = 0; j < entries_per_row_p; j++) begin
      entry    = row_i[j*entry_width_lp +: entry_width_lp];
      hit_o[j] = (entry[entry_width_lp-1 -: tag_width_p] == tag_i)
                 && (entry[coh_width_lp-1:0] != e_COH_I);
      idx      = int'(base_i) + j;
      lce_o[j] = lce_id_width_p'(idx / lce_assoc_p);
      way_o[j] = lce_assoc_width_p'(idx % lce_assoc_p);
    end
  end

endmodule

// File: rtl/bp_cce_dir_sharers_gen.sv
// rtl/bp_cce_dir_sharers_gen.sv - directory way-group walker producing sharers vectors; option BP_CCE_DIR_MULTIHIT_CHECK_EN
module bp_cce_dir_sharers_gen
  import bp_cce_pkg::*;
  #(parameter bp_params_e bp_params_p = e_bp_inv_cfg
   ,parameter int tag_width_p       = 20
   ,parameter int wg_width_p        = 6
   ,parameter int entries_per_row_p = 8
   ,localparam int num_lce_p         = cfg_num_lce(bp_params_p)
   ,localparam int lce_assoc_p       = cfg_lce_assoc(bp_params_p)
   ,localparam int lce_assoc_width_p = safe_clog2(lce_assoc_p)
   ,localparam int lce_id_width_p    = safe_clog2(num_lce_p)
   ,localparam int coh_width_lp      = $bits(bp_coh_states_e)
   ,localparam int entry_width_lp    = tag_width_p + coh_width_lp
   ,localparam int rows_lp           = dir_rows(num_lce_p, lce_assoc_p, entries_per_row_p)
   ,localparam int row_width_lp      = safe_clog2(rows_lp)
   ,localparam int idx_width_lp      = safe_clog2(num_lce_p * lce_assoc_p)
  )
  (input  logic                                              clk_i
  ,input  logic                                              reset_i
  ,input  logic                                              rd_v_i
  ,output logic                                              rd_ready_o
  ,input  logic [wg_width_p-1:0]                             wg_i
  ,input  logic [tag_width_p-1:0]                            tag_i
  ,input  logic [lce_id_width_p-1:0]                         lru_lce_i
  ,input  logic [lce_assoc_width_p-1:0]                      lru_way_i
  ,output logic                                              ram_v_o
  ,output logic [wg_width_p+row_width_lp-1:0]                ram_addr_o
  ,input  logic [entries_per_row_p*entry_width_lp-1:0]       ram_data_i
  ,output logic                                              sharers_v_o
  ,output logic [num_lce_p-1:0]                              sharers_hits_o
  ,output logic [num_lce_p-1:0][lce_assoc_width_p-1:0]       sharers_ways_o
  ,output logic [num_lce_p-1:0][coh_width_lp-1:0]            sharers_coh_states_o
  ,output bp_coh_states_e                                    lru_coh_state_o
  ,output logic [tag_width_p-1:0]                            lru_tag_o
  ,output logic                                              multihit_o
  );

  logic [1:0]                    state_r, state_n;
  logic [row_width_lp-1:0]       row_r, rd_row_r;
  logic                          rd_v_r;
  logic [wg_width_p-1:0]         wg_r;
  logic [tag_width_p-1:0]        tag_r;
  logic [lce_id_width_p-1:0]     lru_lce_r;
  logic [lce_assoc_width_p-1:0]  lru_way_r;
  logic                          accept, last_issue;

  assign rd_ready_o = (state_r == e_ready);
  assign ram_v_o    = (state_r == e_read);
  assign ram_addr_o = {wg_r, row_r};
  assign accept     = rd_ready_o & rd_v_i;
  assign last_issue = (row_r == row_width_lp'(rows_lp - 1));

  // e_done covers the cycle in which the final row's data is folded in
  always_comb begin
    state_n = state_r;
    case (state_r)
      e_ready: if (rd_v_i)     state_n = e_read;
      e_read:  if (last_issue) state_n = e_done;
      e_done:                  state_n = e_ready;
      default:                 state_n = e_ready;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r     <= e_ready;
      row_r       <= '0;
      rd_row_r    <= '0;
      rd_v_r      <= 1'b0;
      wg_r        <= '0;
      tag_r       <= '0;
      lru_lce_r   <= '0;
      lru_way_r   <= '0;
      sharers_v_o <= 1'b0;
    end else begin
      state_r     <= state_n;
      rd_v_r      <= ram_v_o;
      rd_row_r    <= row_r;
      sharers_v_o <= (state_r == e_done);
      if (accept) begin
        wg_r      <= wg_i;
        tag_r     <= tag_i;
        lru_lce_r <= lru_lce_i;
        lru_way_r <= lru_way_i;
        row_r     <= '0;
      end else if (ram_v_o) begin
        row_r     <= row_r + row_width_lp'(1);
      end
    end
  end

  logic [entries_per_row_p-1:0]                         row_hit;
  logic [entries_per_row_p-1:0][lce_id_width_p-1:0]     row_lce;
  logic [entries_per_row_p-1:0][lce_assoc_width_p-1:0]  row_way;
  logic [idx_width_lp-1:0]                              row_base;

  assign row_base = idx_width_lp'(32'(rd_row_r) * entries_per_row_p);

  bp_cce_dir_row_cmp
    #(.tag_width_p(tag_width_p)
     ,.entries_per_row_p(entries_per_row_p)
     ,.lce_assoc_p(lce_assoc_p)
     ,.lce_id_width_p(lce_id_width_p)
     ,.lce_assoc_width_p(lce_assoc_width_p)
     ,.idx_width_p(idx_width_lp))
    row_cmp
    (.row_i(ram_data_i)
    ,.tag_i(tag_r)
    ,.base_i(row_base)
    ,.hit_o(row_hit)
    ,.lce_o(row_lce)
    ,.way_o(row_way)
    );

  logic [num_lce_p-1:0]                         hits_n;
  logic [num_lce_p-1:0][lce_assoc_width_p-1:0]  ways_n;
  logic [num_lce_p-1:0][coh_width_lp-1:0]       states_n;
  bp_coh_states_e                               lru_state_n;
  logic [tag_width_p-1:0]                       lru_tag_n;
  logic [entry_width_lp-1:0]                    entry;
`ifdef BP_CCE_DIR_MULTIHIT_CHECK_EN
  logic                                         multihit_n;
`endif

  // Entries are walked in ascending way order, so the first hit claims the LCE
  always_comb begin
    hits_n      = sharers_hits_o;
    ways_n      = sharers_ways_o;
    states_n    = sharers_coh_states_o;
    lru_state_n = lru_coh_state_o;
    lru_tag_n   = lru_tag_o;
    entry       = '0;
`ifdef BP_CCE_DIR_MULTIHIT_CHECK_EN
    multihit_n  = 1'b0;
`endif
    if (rd_v_r) begin
      for (int j = 0; j < entries_per_row_p; j++) begin
        entry = ram_data_i[j*entry_width_lp +: entry_width_lp];
        if (row_hit[j] && !hits_n[row_lce[j]]) begin
          hits_n[row_lce[j]]   = 1'b1;
          ways_n[row_lce[j]]   = row_way[j];
          states_n[row_lce[j]] = entry[coh_width_lp-1:0];
        end
`ifdef BP_CCE_DIR_MULTIHIT_CHECK_EN
        else if (row_hit[j]) begin
          multihit_n = 1'b1;
        end
`endif
        if (row_lce[j] == lru_lce_r && row_way[j] == lru_way_r) begin
          lru_state_n = bp_coh_states_e'(entry[coh_width_lp-1:0]);
          lru_tag_n   = entry[entry_width_lp-1 -: tag_width_p];
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sharers_hits_o       <= '0;
      sharers_ways_o       <= '0;
      sharers_coh_states_o <= '0;
      lru_coh_state_o      <= e_COH_I;
      lru_tag_o            <= '0;
    end else if (accept) begin
      sharers_hits_o       <= '0;
      sharers_ways_o       <= '0;
      sharers_coh_states_o <= '0;
      lru_coh_state_o      <= e_COH_I;
      lru_tag_o            <= '0;
    end else if (rd_v_r) begin
      sharers_hits_o       <= hits_n;
      sharers_ways_o       <= ways_n;
      sharers_coh_states_o <= states_n;
      lru_coh_state_o      <= lru_state_n;
      lru_tag_o            <= lru_tag_n;
    end
  end

`ifdef BP_CCE_DIR_MULTIHIT_CHECK_EN
  logic multihit_r;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)     multihit_r <= 1'b0;
    else if (accept) multihit_r <= 1'b0;
    else if (rd_v_r) multihit_r <= multihit_r | multihit_n;
  end

  assign multihit_o = multihit_r;

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (!reset_i && sharers_v_o && multihit_r)
      $error("bp_cce_dir_sharers_gen: multiple ways hit within one LCE");
  end
`endif
`else
  assign multihit_o = 1'b0;
`endif

endmodule

// File: tb/tb_bp_cce_dir_sharers_gen.sv
// tb/tb_bp_cce_dir_sharers_gen.sv - vector-table bench for bp_cce_dir_sharers_gen (2 LCE x 2 way, 2 entries/row)
module tb_bp_cce_dir_sharers_gen;
  import bp_cce_pkg::*;

`ifdef BP_CCE_DIR_MULTIHIT_CHECK_EN
  localparam logic mh_en = 1'b1;
`else
  localparam logic mh_en = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              rd_v = 1'b0;
  logic              rd_ready;
  logic [5:0]        wg = '0;
  logic [19:0]       tag = '0;
  logic              lru_lce = 1'b0;
  logic              lru_way = 1'b0;
  logic              ram_v;
  logic [6:0]        ram_addr;
  logic [45:0]       ram_data = '0;
  logic              sharers_v;
  logic [1:0]        hits;
  logic [1:0][0:0]   ways;
  logic [1:0][2:0]   states;
  bp_coh_states_e    lru_state;
  logic [19:0]       lru_tag;
  logic              multihit;

  bp_cce_dir_sharers_gen
    #(.bp_params_p(e_bp_tiny_cfg), .tag_width_p(20), .wg_width_p(6), .entries_per_row_p(2))
    dut
    (.clk_i(clk), .reset_i(reset), .rd_v_i(rd_v), .rd_ready_o(rd_ready)
    ,.wg_i(wg), .tag_i(tag), .lru_lce_i(lru_lce), .lru_way_i(lru_way)
    ,.ram_v_o(ram_v), .ram_addr_o(ram_addr), .ram_data_i(ram_data)
    ,.sharers_v_o(sharers_v), .sharers_hits_o(hits), .sharers_ways_o(ways)
    ,.sharers_coh_states_o(states), .lru_coh_state_o(lru_state), .lru_tag_o(lru_tag)
    ,.multihit_o(multihit));

  always #5 clk = ~clk;

  logic [45:0] mem [128];

  always @(posedge clk) begin
    if (ram_v) ram_data <= mem[ram_addr];
  end

  typedef struct {
    logic [5:0]              wg;
    logic [19:0]             tag;
    logic                    lru_lce;
    logic                    lru_way;
    bp_cce_dir_entry_s [3:0] ents;
    logic [1:0]              hits;
    logic [1:0]              ways;
    logic [5:0]              states;
    bp_coh_states_e          lru_state;
    logic [19:0]             lru_tag;
    logic                    mh;
  } vec_t;

  vec_t vecs [5];
  int   n_cmp  = 0;
  int   n_fail = 0;

  function automatic bp_cce_dir_entry_s ent(input logic [19:0] t, input bp_coh_states_e s);
    bp_cce_dir_entry_s e;
    e.tag   = t;
    e.state = s;
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int i);
    int k;
    k = 0;
    while (!rd_ready && k < 10) begin
      @(negedge clk);
      k++;
    end
    check($sformatf("v%0d_ready", i), 64'(rd_ready), 64'd1);
    rd_v    = 1'b1;
    wg      = vecs[i].wg;
    tag     = vecs[i].tag;
    lru_lce = vecs[i].lru_lce;
    lru_way = vecs[i].lru_way;
    @(negedge clk);
    rd_v = 1'b0;
    k = 1;
    while (!sharers_v && k < 10) begin
      @(negedge clk);
      k++;
    end
    check($sformatf("v%0d_latency", i), 64'(k), 64'd4);
    check($sformatf("v%0d_hits", i), 64'(hits), 64'(vecs[i].hits));
    check($sformatf("v%0d_ways", i), 64'(ways), 64'(vecs[i].ways));
    check($sformatf("v%0d_states", i), 64'(states), 64'(vecs[i].states));
    check($sformatf("v%0d_lru_state", i), 64'(lru_state), 64'(vecs[i].lru_state));
    check($sformatf("v%0d_lru_tag", i), 64'(lru_tag), 64'(vecs[i].lru_tag));
    check($sformatf("v%0d_multihit", i), 64'(multihit), 64'(vecs[i].mh));
    @(negedge clk);
    check($sformatf("v%0d_pulse_end", i), 64'(sharers_v), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc [3];
    int n_acc, n_pulse;

    for (int a = 0; a < 128; a++) mem[a] = '0;

    // ents listed as {e3 (lce1 way1), e2 (lce1 way0), e1 (lce0 way1), e0 (lce0 way0)}
    vecs[0] = '{wg:6'd1, tag:20'h5, lru_lce:1'b1, lru_way:1'b0,
                ents:{ent(20'h5, e_COH_M), ent(20'h11, e_COH_I), ent(20'h0, e_COH_I), ent(20'h0, e_COH_I)},
                hits:2'b10, ways:2'b10, states:{e_COH_M, e_COH_I},
                lru_state:e_COH_I, lru_tag:20'h11, mh:1'b0};
    vecs[1] = '{wg:6'd2, tag:20'h7, lru_lce:1'b1, lru_way:1'b1,
                ents:{ent(20'h8, e_COH_M), ent(20'h7, e_COH_S), ent(20'h0, e_COH_I), ent(20'h7, e_COH_S)},
                hits:2'b11, ways:2'b00, states:{e_COH_S, e_COH_S},
                lru_state:e_COH_M, lru_tag:20'h8, mh:1'b0};
    vecs[2] = '{wg:6'd3, tag:20'h3, lru_lce:1'b0, lru_way:1'b1,
                ents:{ent(20'h3, e_COH_I), ent(20'h4, e_COH_E), ent(20'h3, e_COH_S), ent(20'h3, e_COH_S)},
                hits:2'b01, ways:2'b00, states:{e_COH_I, e_COH_S},
                lru_state:e_COH_S, lru_tag:20'h3, mh:mh_en};
    vecs[3] = '{wg:6'd4, tag:20'hA, lru_lce:1'b0, lru_way:1'b1,
                ents:{ent(20'hA, e_COH_I), ent(20'h0, e_COH_I), ent(20'h9, e_COH_E), ent(20'hA, e_COH_I)},
                hits:2'b00, ways:2'b00, states:{e_COH_I, e_COH_I},
                lru_state:e_COH_E, lru_tag:20'h9, mh:1'b0};
    vecs[4] = '{wg:6'd63, tag:20'h12, lru_lce:1'b1, lru_way:1'b0,
                ents:{ent(20'h0, e_COH_I), ent(20'hFFFFF, e_COH_F), ent(20'h12, e_COH_O), ent(20'h13, e_COH_S)},
                hits:2'b01, ways:2'b01, states:{e_COH_I, e_COH_O},
                lru_state:e_COH_F, lru_tag:20'hFFFFF, mh:1'b0};

    for (int i = 0; i < 5; i++) begin
      mem[{vecs[i].wg, 1'b0}] = vecs[i].ents[1:0];
      mem[{vecs[i].wg, 1'b1}] = vecs[i].ents[3:2];
    end

    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready", 64'(rd_ready), 64'd1);
    check("rst_ram_v", 64'(ram_v), 64'd0);
    check("rst_sharers_v", 64'(sharers_v), 64'd0);
    check("rst_hits", 64'(hits), 64'd0);
    check("rst_multihit", 64'(multihit), 64'd0);

    for (int i = 0; i < 5; i++) run_vec(i);

    // Abort a lookup with reset in its second cycle
    rd_v    = 1'b1;
    wg      = vecs[0].wg;
    tag     = vecs[0].tag;
    lru_lce = vecs[0].lru_lce;
    lru_way = vecs[0].lru_way;
    @(negedge clk);
    rd_v = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_ready", 64'(rd_ready), 64'd1);
    check("abort_ram_v", 64'(ram_v), 64'd0);
    check("abort_sharers_v", 64'(sharers_v), 64'd0);
    check("abort_hits", 64'(hits), 64'd0);
    check("abort_ways", 64'(ways), 64'd0);
    check("abort_states", 64'(states), 64'd0);
    check("abort_lru_state", 64'(lru_state), 64'd0);
    check("abort_lru_tag", 64'(lru_tag), 64'd0);
    check("abort_multihit", 64'(multihit), 64'd0);
    n_pulse = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (sharers_v) n_pulse++;
    end
    check("abort_no_pulse", 64'(n_pulse), 64'd0);
    run_vec(1);

    // rd_v held high: accepts every 4 cycles, one pulse each
    rd_v    = 1'b1;
    wg      = vecs[1].wg;
    tag     = vecs[1].tag;
    lru_lce = vecs[1].lru_lce;
    lru_way = vecs[1].lru_way;
    n_acc   = 0;
    n_pulse = 0;
    for (int k = 0; k <= 12; k++) begin
      if (k > 0) @(negedge clk);
      if (k <= 11 && rd_ready) begin
        if (n_acc < 3) acc[n_acc] = k;
        n_acc++;
      end
      if (k >= 1 && sharers_v) n_pulse++;
    end
    rd_v = 1'b0;
    check("b2b_accepts", 64'(n_acc), 64'd3);
    check("b2b_pulses", 64'(n_pulse), 64'd3);
    check("b2b_first", 64'(acc[0]), 64'd0);
    check("b2b_gap0", 64'(acc[1] - acc[0]), 64'd4);
    check("b2b_gap1", 64'(acc[2] - acc[1]), 64'd4);
    check("b2b_hits", 64'(hits), 64'(vecs[1].hits));
    check("b2b_lru_tag", 64'(lru_tag), 64'(vecs[1].lru_tag));
    repeat (6) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bp_cce_dir_sharers_gen.md
Name: bp_cce_dir_sharers_gen

Overview:
- Reads one directory way-group from the directory RAM, one row per cycle, and compares each entry's tag against a target tag.
- Consolidates the results into the per-LCE hit, way and coherence-state vectors that the CCE's auxiliary-flag logic consumes.
- Also captures the requesting LCE's LRU entry state and tag.
- Sits between the directory RAM and the CCE flag-generation stage. It is the producer side of the sharers interface.

Parameters:
- bp_params_p, e_bp_inv_cfg: supplies num_lce_p, lce_assoc_p, lce_assoc_width_p, lce_id_width_p.
- tag_width_p, 20: directory tag width.
- wg_width_p, 6: way-group index width.
- entries_per_row_p, 8: entries returned per RAM row. (num_lce_p*lce_assoc_p) % entries_per_row_p must be 0.
- Local rows_lp = num_lce_p*lce_assoc_p/entries_per_row_p. Entry width = tag_width_p + $bits(bp_coh_states_e).

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  reset. Asynchronous, active-high.
- rd_v_i  in  1  lookup request valid.
- rd_ready_o  out  1  ready to accept a request.
- wg_i  in  wg_width_p  way-group index.
- tag_i  in  tag_width_p  target tag.
- lru_lce_i  in  lce_id_width_p  requesting LCE.
- lru_way_i  in  lce_assoc_width_p  LRU way in the requesting LCE.
- ram_v_o  out  1  RAM read enable.
- ram_addr_o  out  wg_width_p+clog2(rows_lp)  RAM address = {wg, row}.
- ram_data_i  in  entries_per_row_p*entry width  row data. Arrives 1 cycle after ram_v_o. Entry 0 is at the LSBs.
- sharers_v_o  out  1  one-cycle pulse: vectors are complete.
- sharers_hits_o  out  num_lce_p  per-LCE tag hit.
- sharers_ways_o  out  num_lce_p x lce_assoc_width_p  hit way per LCE.
- sharers_coh_states_o  out  num_lce_p x bp_coh_states_e  state of the hit entry per LCE.
- lru_coh_state_o  out  bp_coh_states_e  state of the LRU entry.
- lru_tag_o  out  tag_width_p  tag of the LRU entry.
- multihit_o  out  1  more than one way hit in a single LCE (see Optional Feature).

Behaviour:
- Entry mapping: global entry index e = lce*lce_assoc_p + way. Row k holds entries k*entries_per_row_p through k*entries_per_row_p + entries_per_row_p - 1.
- Hit rule: entry tag == latched tag AND entry state != e_COH_I.
- State machine has three states: e_ready, e_read, e_done.
  - e_ready: rd_ready_o=1. On rd_v_i, latch wg/tag/lru_lce/lru_way, clear all accumulators and multihit, set row counter to 0, go to e_read.
  - e_read: ram_v_o=1 with row = counter; counter increments each cycle. A one-cycle-delayed valid/row register processes ram_data_i. When the last row has been issued, stop issuing. When the last row's data has been processed, go to e_done.
  - e_done: sharers_v_o=1 for exactly one cycle, then go to e_ready.
- Latency: request accepted in cycle 0 → ram_v_o asserted in cycles 1..rows_lp → sharers_v_o in cycle rows_lp+2.
- Throughput: one lookup every rows_lp+2 cycles. rd_ready_o=0 outside e_ready.
- Multiple hits within one LCE: the lowest way wins, because a hit bit that is already set blocks later updates for that LCE.
- LRU capture: happens when entry lru_lce*lce_assoc_p + lru_way is processed, irrespective of the hit rule.
- All outputs are registered and held stable from sharers_v_o until the next accept.
- Reset value of every output and register is 0; states reset to e_COH_I. After reset the FSM is in e_ready.
- Reset mid-lookup aborts the lookup. A RAM response that arrives after reset is ignored, because the delayed valid is cleared.
- A request that arrives in the same cycle as e_done is not accepted.

Optional Feature:
- Macro: BP_CCE_DIR_MULTIHIT_CHECK_EN.
- Defined: multihit_o is a sticky flag set during a lookup when a second hit occurs in an LCE already marked hit. It is cleared on accept and valid when sharers_v_o is asserted. Simulation also raises $error on the sharers_v_o cycle.
- Undefined: multihit_o is tied to 0 and no detection logic is built.

Decomposition:
- Package bp_cce_pkg holds the dir entry struct {tag, bp_coh_states_e state}, the FSM state enum, and a row-count helper.
- Natural sub-module: bp_cce_dir_row_cmp. It is combinational: given one row, the latched tag and the base entry index, it produces per-entry hit, LCE and way for the accumulator.

Test Plan:
- Config num_lce=2, assoc=2, entries_per_row=2 (2 rows). LCE1 way1 tag 0x5 in M, others I; lookup tag 0x5 → hits=2'b10, ways[1]=1, states[1]=e_COH_M, sharers_v_o in cycle 4.
- LCE0 way0 in S and LCE1 way0 in S, tag 0x7 → hits=2'b11, both ways 0, both states S.
- LCE0 ways 0 and 1 both tag 0x3 in S → way 0 reported; multihit_o=1 with macro, 0 without.
- Tag matches but state is e_COH_I → hits=0. LRU lce=0, way=1, entry {0x9, E} → lru_coh_state_o=E, lru_tag_o=0x9.
- Assert reset in cycle 2 of a lookup → all outputs are 0 and rd_ready_o=1 after deassert. The next lookup completes normally.
- Back-to-back rd_v_i held high → accepts spaced exactly 4 cycles apart, one sharers_v_o pulse per accept.
